// File: rtl/secded_pkg.sv
// Shared widths, codeword position map and error classes for the SECDED decoder.
package secded_pkg;

    typedef enum logic [1:0] {
        CLEAN = 2'd0,
        CE    = 2'd1,
        UE    = 2'd2
    } err_class_e;

    // Smallest r with 2^r >= data_w + r + 1; scanned downward so the last hit is the smallest.
    function automatic int calc_p_w(input int data_w);
        int r;
        r = 32'sd0;
        for (int i = 32'sd8; i >= 32'sd1; i--) begin
            if ((32'sd1 << i) >= (data_w + i + 32'sd1)) begin
                r = i;
            end
        end
        return r;
    endfunction

    function automatic int calc_code_w(input int data_w);
        return data_w + calc_p_w(data_w) + 32'sd1;
    endfunction

    // Data index stored at Hamming position pos, or -1 for check-bit / parity positions.
    function automatic int pos_to_data_idx(input int pos);
        int npow;
        npow = 32'sd0;
        if (pos <= 32'sd0) begin
            return -32'sd1;
        end
        if ((pos & (pos - 32'sd1)) == 32'sd0) begin
            return -32'sd1;
        end
        for (int i = 32'sd0; i < 32'sd8; i++) begin
            if ((32'sd1 << i) <= pos) begin
                npow = npow + 32'sd1;
            end
        end
        return pos - npow - 32'sd1;
    endfunction

endpackage

// File: rtl/secded_syn_calc.sv
// Combinational Hamming syndrome and overall parity of a received codeword.
module secded_syn_calc #(
    parameter int CODE_W = 72,
    parameter int P_W    = 7
) (
    input  logic [CODE_W-1:0] code,
    output logic [P_W-1:0]    syn,
    output logic              par
);

    // syndrome is the XOR of the indices of all set positions
    always_comb begin
        syn = '0;
        for (int k = 1; k < CODE_W; k++) begin
            syn = syn ^ ({P_W{code[k]}} & P_W'(k));
        end
        par = ^code;
    end

endmodule

// File: rtl/secded_dec_pipe.sv
// Two-stage pipelined SECDED decoder with valid/ready flow control.
// Optional error statistics are built when SECDED_ERR_CNT_EN is defined.
module secded_dec_pipe
    import secded_pkg::*;
#(
    parameter int DATA_W = 64,
`ifdef SECDED_ERR_CNT_EN
    parameter int CNT_W  = 16,
`endif
    localparam int P_W    = calc_p_w(DATA_W),
    localparam int CODE_W = calc_code_w(DATA_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CODE_W-1:0] in_code,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_ce,
    output logic              out_ue,
    output logic [P_W-1:0]    out_syn
`ifdef SECDED_ERR_CNT_EN
    ,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  ce_cnt,
    output logic [CNT_W-1:0]  ue_cnt,
    output logic              err_cap_vld,
    output logic [P_W-1:0]    err_cap_syn
`endif
);

    logic              adv_s;
    logic [P_W-1:0]    syn_s;
    logic              par_s;
    logic              s1_vld_r;
    logic [CODE_W-1:0] s1_code_r;
    logic [P_W-1:0]    s1_syn_r;
    logic              s1_par_r;
    err_class_e        cls_s;
    logic [CODE_W-1:0] flip_s;
    logic [CODE_W-1:0] corr_s;
    logic [DATA_W-1:0] data_s;
    logic              unused_code_s;

    // Whole pipe advances as one; a stall freezes both stages.
    assign adv_s    = !out_valid || out_ready;
    assign in_ready = adv_s;

    secded_syn_calc #(
        .CODE_W (CODE_W),
        .P_W    (P_W)
    ) u_syn_calc (
        .code (in_code),
        .syn  (syn_s),
        .par  (par_s)
    );

    // stage 1: codeword, syndrome and parity
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_r  <= 1'b0;
            s1_code_r <= '0;
            s1_syn_r  <= '0;
            s1_par_r  <= 1'b0;
        end else if (adv_s) begin
            s1_vld_r <= in_valid;
            if (in_valid) begin
                s1_code_r <= in_code;
                s1_syn_r  <= syn_s;
                s1_par_r  <= par_s;
            end
        end
    end

    // classify; syndromes beyond the last position cannot be a single flip
    always_comb begin
        cls_s = CLEAN;
        if (s1_par_r) begin
            if (32'(s1_syn_r) > 32'(CODE_W - 1)) begin
                cls_s = UE;
            end else begin
                cls_s = CE;
            end
        end else begin
            if (s1_syn_r != '0) begin
                cls_s = UE;
            end else begin
                cls_s = CLEAN;
            end
        end
    end

    // single-bit correction mask; syndrome 0 flips only the parity bit
    always_comb begin
        flip_s = '0;
        for (int k = 0; k < CODE_W; k++) begin
            flip_s[k] = (cls_s == CE) && (s1_syn_r == P_W'(k));
        end
    end

    assign corr_s        = s1_code_r ^ flip_s;
    assign unused_code_s = ^corr_s;

    for (genvar k = 1; k < CODE_W; k++) begin : g_extract
        if (pos_to_data_idx(k) >= 0) begin : g_data
            assign data_s[pos_to_data_idx(k)] = corr_s[k];
        end
    end

    // stage 2: corrected payload and flags
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ce    <= 1'b0;
            out_ue    <= 1'b0;
            out_syn   <= '0;
        end else if (adv_s) begin
            out_valid <= s1_vld_r;
            if (s1_vld_r) begin
                out_data <= data_s;
                out_ce   <= (cls_s == CE);
                out_ue   <= (cls_s == UE);
                out_syn  <= s1_syn_r;
            end
        end
    end

`ifdef SECDED_ERR_CNT_EN
    logic xfer_s;

    assign xfer_s = out_valid && out_ready;

    // saturating counters and first-error capture, clear has priority
    always_ff @(posedge clk) begin
        if (rst) begin
            ce_cnt      <= '0;
            ue_cnt      <= '0;
            err_cap_vld <= 1'b0;
            err_cap_syn <= '0;
        end else if (cnt_clr) begin
            ce_cnt      <= '0;
            ue_cnt      <= '0;
            err_cap_vld <= 1'b0;
        end else if (xfer_s) begin
            if (out_ce && (ce_cnt != {CNT_W{1'b1}})) begin
                ce_cnt <= ce_cnt + CNT_W'(1);
            end
            if (out_ue && (ue_cnt != {CNT_W{1'b1}})) begin
                ue_cnt <= ue_cnt + CNT_W'(1);
            end
            if ((out_ce || out_ue) && !err_cap_vld) begin
                err_cap_vld <= 1'b1;
                err_cap_syn <= out_syn;
            end
        end
    end
`endif

endmodule

// File: tb/tb_secded_dec_pipe.sv
// Directed self-checking bench for secded_dec_pipe (DATA_W=64, CNT_W=4 when counters are built).
module tb_secded_dec_pipe;

    localparam int DATA_W = 64;
    localparam int P_W    = 7;
    localparam int CODE_W = 72;
    localparam int CNT_W  = 4;

    localparam logic [63:0] D0 = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] D1 = 64'hFEDC_BA98_7654_3210;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [CODE_W-1:0] in_code;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_ce;
    logic              out_ue;
    logic [P_W-1:0]    out_syn;
`ifdef SECDED_ERR_CNT_EN
    logic              cnt_clr;
    logic [CNT_W-1:0]  ce_cnt;
    logic [CNT_W-1:0]  ue_cnt;
    logic              err_cap_vld;
    logic [P_W-1:0]    err_cap_syn;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    secded_dec_pipe #(
        .DATA_W (DATA_W)
`ifdef SECDED_ERR_CNT_EN
        ,
        .CNT_W  (CNT_W)
`endif
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_code     (in_code),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_ce      (out_ce),
        .out_ue      (out_ue),
        .out_syn     (out_syn)
`ifdef SECDED_ERR_CNT_EN
        ,
        .cnt_clr     (cnt_clr),
        .ce_cnt      (ce_cnt),
        .ue_cnt      (ue_cnt),
        .err_cap_vld (err_cap_vld),
        .err_cap_syn (err_cap_syn)
`endif
    );

    // Reference encoder: data fills non-power-of-two positions from 3 upward.
    function automatic logic [71:0] encode(input logic [63:0] d);
        logic [71:0] c;
        logic        b;
        int          di;
        c  = '0;
        di = 0;
        for (int k = 1; k < 72; k++) begin
            if ((k & (k - 1)) != 0) begin
                c[k] = d[di];
                di++;
            end
        end
        for (int j = 0; j < 7; j++) begin
            b = 1'b0;
            for (int k = 1; k < 72; k++) begin
                if ((((k >> j) & 1) == 1) && (k != (1 << j))) b = b ^ c[k];
            end
            c[1 << j] = b;
        end
        c[0] = ^c[71:1];
        return c;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sends one word through an idle pipe and captures what emerges.
    task automatic run_word(input logic [71:0] code, output logic lat_ok,
                            output logic [63:0] d, output logic ce, output logic ue,
                            output logic [6:0] syn);
        logic v1;
        in_valid  = 1'b1;
        in_code   = code;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        v1 = out_valid;
        tick();
        lat_ok = (v1 === 1'b0) && (out_valid === 1'b1);
        d   = out_data;
        ce  = out_ce;
        ue  = out_ue;
        syn = out_syn;
        tick();
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_code   = '0;
        out_ready = 1'b1;
`ifdef SECDED_ERR_CNT_EN
        cnt_clr   = 1'b0;
`endif
        tick();
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", out_valid); end
        checks++; if (out_data !== 64'h0) begin errors++; $display("FAIL reset_data got %h exp 0", out_data); end
        checks++; if ({out_ce, out_ue} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b exp 00", {out_ce, out_ue}); end
        checks++; if (out_syn !== 7'd0) begin errors++; $display("FAIL reset_syn got %0d exp 0", out_syn); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b exp 1", in_ready); end
`ifdef SECDED_ERR_CNT_EN
        checks++; if ({ce_cnt, ue_cnt} !== 8'h00) begin errors++; $display("FAIL reset_cnt got %h exp 00", {ce_cnt, ue_cnt}); end
        checks++; if ({err_cap_vld, err_cap_syn} !== 8'h00) begin errors++; $display("FAIL reset_cap got %h exp 00", {err_cap_vld, err_cap_syn}); end
`endif
        rst = 1'b0;
    endtask

    task automatic test_clean();
        logic lat; logic [63:0] d; logic ce, ue; logic [6:0] syn;
        run_word(encode(D0), lat, d, ce, ue, syn);
        checks++; if (lat !== 1'b1) begin errors++; $display("FAIL clean_latency got %0b exp 1", lat); end
        checks++; if (d !== D0) begin errors++; $display("FAIL clean_data got %h exp %h", d, D0); end
        checks++; if ({ce, ue} !== 2'b00) begin errors++; $display("FAIL clean_flags got %b exp 00", {ce, ue}); end
        checks++; if (syn !== 7'd0) begin errors++; $display("FAIL clean_syn got %0d exp 0", syn); end
    endtask

    task automatic test_single_error();
        logic lat; logic [63:0] d; logic ce, ue; logic [6:0] syn;
        run_word(encode(D0) ^ (72'h1 << 3), lat, d, ce, ue, syn);
        checks++; if (d !== D0) begin errors++; $display("FAIL ce3_data got %h exp %h", d, D0); end
        checks++; if ({ce, ue} !== 2'b10) begin errors++; $display("FAIL ce3_flags got %b exp 10", {ce, ue}); end
        checks++; if (syn !== 7'd3) begin errors++; $display("FAIL ce3_syn got %0d exp 3", syn); end
        run_word(encode(D0) ^ 72'h1, lat, d, ce, ue, syn);
        checks++; if (d !== D0) begin errors++; $display("FAIL ce0_data got %h exp %h", d, D0); end
        checks++; if ({ce, ue} !== 2'b10) begin errors++; $display("FAIL ce0_flags got %b exp 10", {ce, ue}); end
        checks++; if (syn !== 7'd0) begin errors++; $display("FAIL ce0_syn got %0d exp 0", syn); end
        run_word(encode(D1) ^ (72'h1 << 71), lat, d, ce, ue, syn);
        checks++; if (d !== D1) begin errors++; $display("FAIL ce71_data got %h exp %h", d, D1); end
        checks++; if ({ce, ue, syn} !== {2'b10, 7'd71}) begin errors++; $display("FAIL ce71_flags_syn got %b/%0d exp 10/71", {ce, ue}, syn); end
    endtask

    task automatic test_double_error();
        logic lat; logic [63:0] d; logic ce, ue; logic [6:0] syn;
        // positions 3 and 5 hold data[0] and data[1]
        run_word(encode(D0) ^ (72'h1 << 3) ^ (72'h1 << 5), lat, d, ce, ue, syn);
        checks++; if (d !== 64'h0123_4567_89AB_CDEC) begin errors++; $display("FAIL ue_data got %h exp 0123456789abcdec", d); end
        checks++; if ({ce, ue} !== 2'b01) begin errors++; $display("FAIL ue_flags got %b exp 01", {ce, ue}); end
        checks++; if (syn !== 7'd6) begin errors++; $display("FAIL ue_syn got %0d exp 6", syn); end
        // odd parity with syndrome 73, beyond the last position
        run_word(encode(D0) ^ (72'h1 << 1) ^ (72'h1 << 8) ^ (72'h1 << 64), lat, d, ce, ue, syn);
        checks++; if (d !== D0) begin errors++; $display("FAIL ue73_data got %h exp %h", d, D0); end
        checks++; if ({ce, ue, syn} !== {2'b01, 7'd73}) begin errors++; $display("FAIL ue73_flags_syn got %b/%0d exp 01/73", {ce, ue}, syn); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] dw [8];
        logic [71:0] cw [8];
        logic [63:0] held_data;
        logic        held;
        int sent, rcvd, cyc;
        for (int i = 0; i < 8; i++) begin
            dw[i] = 64'h0F0F_0000_0000_0000 ^ (64'(i + 1) * 64'h0101_0101_0101_0101);
            cw[i] = encode(dw[i]);
        end
        cw[2] = cw[2] ^ (72'h1 << 10);
        sent = 0; rcvd = 0; cyc = 0; held = 1'b0; held_data = '0;
        while ((rcvd < 8) && (cyc < 40)) begin
            out_ready = !((cyc >= 3) && (cyc <= 5));
            in_valid  = (sent < 8);
            in_code   = (sent < 8) ? cw[sent] : '0;
            #1;
            if (cyc == 2) begin
                checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_first_latency got %0b exp 1", out_valid); end
            end
            if (!out_ready) begin
                checks++; if ({out_valid, in_ready} !== 2'b10) begin errors++; $display("FAIL b2b_stall cyc %0d valid/ready got %b exp 10", cyc, {out_valid, in_ready}); end
                if (held) begin
                    checks++; if (out_data !== held_data) begin errors++; $display("FAIL b2b_hold cyc %0d got %h exp %h", cyc, out_data, held_data); end
                end
                held = 1'b1;
                held_data = out_data;
            end else begin
                held = 1'b0;
            end
            if (out_valid && out_ready) begin
                checks++; if ({out_data, out_ce} !== {dw[rcvd], (rcvd == 2)}) begin errors++; $display("FAIL b2b_word %0d got %h/%0b exp %h/%0b", rcvd, out_data, out_ce, dw[rcvd], (rcvd == 2)); end
                rcvd++;
            end
            if (in_valid && in_ready) sent++;
            tick();
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checks++; if (rcvd !== 8) begin errors++; $display("FAIL b2b_count got %0d exp 8 within 40 cycles", rcvd); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_extra got valid %0b exp 0", out_valid); end
    endtask

    task automatic test_reset_midstream();
        logic seen;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_code   = encode(D0);
        tick();
        in_code   = encode(D1);
        tick();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rstmid_inflight got %0b exp 1", out_valid); end
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %0b exp 0", out_valid); end
        rst       = 1'b0;
        out_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rstmid_emitted got %0b exp 0", seen); end
    endtask

`ifdef SECDED_ERR_CNT_EN
    task automatic test_counters();
        logic lat; logic [63:0] d; logic ce, ue; logic [6:0] syn;
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        checks++; if ({ce_cnt, ue_cnt, err_cap_vld} !== 9'h0) begin errors++; $display("FAIL cnt_clear got %h exp 0", {ce_cnt, ue_cnt, err_cap_vld}); end
        for (int i = 0; i < 20; i++) begin
            run_word(encode(D0 ^ 64'(i)) ^ (72'h1 << (9 + i)), lat, d, ce, ue, syn);
        end
        checks++; if (ce_cnt !== 4'd15) begin errors++; $display("FAIL cnt_ce_sat got %0d exp 15", ce_cnt); end
        checks++; if (ue_cnt !== 4'd0) begin errors++; $display("FAIL cnt_ue got %0d exp 0", ue_cnt); end
        checks++; if ({err_cap_vld, err_cap_syn} !== {1'b1, 7'd9}) begin errors++; $display("FAIL cnt_cap got %0b/%0d exp 1/9", err_cap_vld, err_cap_syn); end
        // park a ce word at the output, then clear in its transfer cycle
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_code   = encode(D0) ^ (72'h1 << 3);
        tick();
        in_valid = 1'b0;
        tick();
        out_ready = 1'b1;
        cnt_clr   = 1'b1;
        tick();
        cnt_clr = 1'b0;
        checks++; if ({ce_cnt, err_cap_vld} !== 5'h0) begin errors++; $display("FAIL cnt_clr_wins got %0d/%0b exp 0/0", ce_cnt, err_cap_vld); end
        run_word(encode(D0) ^ (72'h1 << 3) ^ (72'h1 << 5), lat, d, ce, ue, syn);
        checks++; if ({ce_cnt, ue_cnt} !== {4'd0, 4'd1}) begin errors++; $display("FAIL cnt_ue_inc got %0d/%0d exp 0/1", ce_cnt, ue_cnt); end
        checks++; if ({err_cap_vld, err_cap_syn} !== {1'b1, 7'd6}) begin errors++; $display("FAIL cnt_recap got %0b/%0d exp 1/6", err_cap_vld, err_cap_syn); end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_clean();
        test_single_error();
        test_double_error();
        test_back_to_back();
        test_reset_midstream();
`ifdef SECDED_ERR_CNT_EN
        test_counters();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
